dmem_lsu: RTL

Parametrised, pipelined data memory for the RISC-V core's memory stage. Successor to the single-cycle data RAM, it adds:
- configurable depth and read latency;
- a valid/ready request port and a response port;
- byte-lane write strobes instead of read-modify-write;
- misalignment and out-of-range fault reporting;
- a post-reset memory-clear state machine.

It sits between the execute stage and the writeback mux and serves LB/LH/LW/LBU/LHU/SB/SH/SW.

---
 rtl/dmem_lsu.sv | 94 +++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: pipelined byte-strobed data memory with fault checks and post-reset clear
module dmem_lsu #(
  parameter int ADDR_W = 11,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        init_done
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] idx, widx;
  logic [31:0] mem [DEPTH];
  logic acc, fault;
  logic [3:0] be;
  logic [31:0] wlane, word, shifted, ld, data0;
  logic pv [READ_LAT];
  logic [31:0] pd [READ_LAT];
  logic pf [READ_LAT];
  assign req_ready = state == RUN;
  assign init_done = state == RUN;
  assign widx = req_addr[ADDR_W+1:2];
  assign acc = req_valid && req_ready && !rst;
  assign rsp_valid = pv[READ_LAT-1];
  assign rsp_rdata = pd[READ_LAT-1];
  assign rsp_fault = pf[READ_LAT-1];
  // leave INIT once the last word has been cleared
  always_comb state_n = (state == INIT && &idx) ? RUN : state;
  // state register and clear index
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      idx <= '0;
    end else begin
      state <= state_n;
      if (state == INIT) idx <= idx + 1'b1;
    end
  end
  // request decode: fault detection, byte strobes, lane data and load extension
  always_comb begin
    fault = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
            (req_size == 2'b10 && |req_addr[1:0]) || |(req_addr >> (ADDR_W + 2));
    be = fault ? 4'b0000 : req_size == 2'b00 ? 4'b0001 << req_addr[1:0] :
         req_size == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wlane = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
            req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    word = mem[widx];
    shifted = word >> {req_addr[1:0], 3'b000};
    ld = req_size == 2'b00 ? {{24{~req_unsigned & shifted[7]}}, shifted[7:0]} :
         req_size == 2'b01 ? {{16{~req_unsigned & shifted[15]}}, shifted[15:0]} : word;
    data0 = (fault || req_we) ? 32'h0 : ld;
  end
  // memory: clear sweep during INIT, strobed store commit on acceptance
  always_ff @(posedge clk) begin
    if (state == INIT && !rst) mem[idx] <= '0;
    else if (acc && req_we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
  end
  // response pipeline; data stages only load behind a valid so outputs hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
        pf[i] <= 1'b0;
      end
    end else begin
      pv[0] <= acc;
      if (acc) begin
        pd[0] <= data0;
        pf[0] <= fault;
      end
      for (int i = 1; i < READ_LAT; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) begin
          pd[i] <= pd[i-1];
          pf[i] <= pf[i-1];
        end
      end
    end
  end
endmodule
